// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: 32 shift-add / restoring shift-subtract steps per op.
// Optional early completion for trivial operands is built only when MULDIV_EARLY_OUT_EN is defined.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_md_i,
  input  logic [2:0]      op_md_i,
  input  logic [XLEN-1:0] opr_a_md_i,
  input  logic [XLEN-1:0] opr_b_md_i,
  input  logic            kill_md_i,
  output logic            ready_md_o,
  output logic            busy_md_o,
  output logic            done_md_o,
  output logic [XLEN-1:0] res_md_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                a_neg_q, a_neg_d;
  logic                b_neg_q, b_neg_d;
  logic                div_zero_q, div_zero_d;
  logic [XLEN-1:0]     shreg_q, shreg_d;
  logic [XLEN-1:0]     addend_q, addend_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     res_q, res_d;

  // Operand conditioning at accept: MULHSU treats only a as signed, MULHU/DIVU/REMU neither.
  logic            in_is_div, in_a_signed, in_b_signed, in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_a_abs, in_b_abs;

  assign in_is_div   = op_md_i[2];
  assign in_a_signed = in_is_div ? ~op_md_i[0] : (op_md_i[1:0] != 2'b11);
  assign in_b_signed = in_is_div ? ~op_md_i[0] : ~op_md_i[1];
  assign in_a_neg    = in_a_signed & opr_a_md_i[XLEN-1];
  assign in_b_neg    = in_b_signed & opr_b_md_i[XLEN-1];
  assign in_a_abs    = in_a_neg ? -opr_a_md_i : opr_a_md_i;
  assign in_b_abs    = in_b_neg ? -opr_b_md_i : opr_b_md_i;

  // One iteration. Multiply consumes the multiplier MSB-first from shreg; divide shifts
  // dividend bits from shreg into the remainder half of acc, quotient bits into the low half.
  logic [2*XLEN-1:0] mul_step, div_step, acc_step;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [XLEN-1:0]   rem_new;
  logic              q_bit;

  always_comb begin
    mul_step = acc_q << 1;
    if (shreg_q[XLEN-1]) begin
      mul_step = (acc_q << 1) + {{XLEN{1'b0}}, addend_q};
    end
    rem_sh   = {acc_q[2*XLEN-1:XLEN], shreg_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, addend_q};
    q_bit    = ~rem_diff[XLEN];
    rem_new  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_step = {rem_new, acc_q[XLEN-2:0], q_bit};
    acc_step = op_q[2] ? div_step : mul_step;
  end

  // Sign correction of the final magnitudes.
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_mag, rem_mag, quo_fin, rem_fin, final_res;

  always_comb begin
    prod_fin = (a_neg_q ^ b_neg_q) ? -acc_step : acc_step;
    quo_mag  = acc_step[XLEN-1:0];
    rem_mag  = acc_step[2*XLEN-1:XLEN];
    quo_fin  = div_zero_q ? {XLEN{1'b1}} : ((a_neg_q ^ b_neg_q) ? -quo_mag : quo_mag);
    rem_fin  = a_neg_q ? -rem_mag : rem_mag;
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_fin : quo_fin;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_q, early_d;
  logic [XLEN-1:0] early_res_q, early_res_d;
  logic            in_early;
  logic [XLEN-1:0] in_early_res;

  always_comb begin
    in_early     = 1'b0;
    in_early_res = '0;
    if (in_is_div) begin
      if (opr_b_md_i == '0) begin
        in_early     = 1'b1;
        in_early_res = op_md_i[1] ? opr_a_md_i : {XLEN{1'b1}};
      end else if (!op_md_i[0] && opr_a_md_i == {1'b1, {(XLEN-1){1'b0}}}
                   && opr_b_md_i == {XLEN{1'b1}}) begin
        in_early     = 1'b1;
        in_early_res = op_md_i[1] ? '0 : opr_a_md_i;
      end
    end else if (opr_a_md_i == '0 || opr_b_md_i == '0) begin
      in_early = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    div_zero_d = div_zero_q;
    shreg_d    = shreg_q;
    addend_d   = addend_q;
    acc_d      = acc_q;
    res_d      = res_q;
`ifdef MULDIV_EARLY_OUT_EN
    early_d     = early_q;
    early_res_d = early_res_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_md_i && !kill_md_i) begin
          state_d    = S_CALC;
          cnt_d      = '0;
          op_d       = op_md_i;
          a_neg_d    = in_a_neg;
          b_neg_d    = in_b_neg;
          div_zero_d = (opr_b_md_i == '0);
          shreg_d    = in_is_div ? in_a_abs : in_b_abs;
          addend_d   = in_is_div ? in_b_abs : in_a_abs;
          acc_d      = '0;
`ifdef MULDIV_EARLY_OUT_EN
          early_d     = in_early;
          early_res_d = in_early_res;
`endif
        end
      end
      S_CALC: begin
        if (kill_md_i) begin
          state_d = S_IDLE;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (early_q) begin
          state_d = S_DONE;
          res_d   = early_res_q;
`endif
        end else begin
          acc_d   = acc_step;
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == LAST_CNT) begin
            state_d = S_DONE;
            res_d   = final_res;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      shreg_q    <= '0;
      addend_q   <= '0;
      acc_q      <= '0;
      res_q      <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q     <= 1'b0;
      early_res_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      div_zero_q <= div_zero_d;
      shreg_q    <= shreg_d;
      addend_q   <= addend_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
`ifdef MULDIV_EARLY_OUT_EN
      early_q     <= early_d;
      early_res_q <= early_res_d;
`endif
    end
  end

  assign ready_md_o = (state_q == S_IDLE);
  assign busy_md_o  = (state_q == S_CALC) || (state_q == S_DONE);
  assign done_md_o  = (state_q == S_DONE);
  assign res_md_o   = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops against a
// cycle-level behavioural model. Honours MULDIV_EARLY_OUT_EN for expected latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_md_i = 1'b0;
  logic [2:0]  op_md_i = 3'd0;
  logic [31:0] opr_a_md_i = 32'd0;
  logic [31:0] opr_b_md_i = 32'd0;
  logic        kill_md_i = 1'b0;
  logic        ready_md_o, busy_md_o, done_md_o;
  logic [31:0] res_md_o;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_md_i (valid_md_i),
    .op_md_i    (op_md_i),
    .opr_a_md_i (opr_a_md_i),
    .opr_b_md_i (opr_b_md_i),
    .kill_md_i  (kill_md_i),
    .ready_md_o (ready_md_o),
    .busy_md_o  (busy_md_o),
    .done_md_o  (done_md_o),
    .res_md_o   (res_md_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of an RV32M op from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] sx, zx, sy, zy, p;
    logic        ovf;
    sx  = {{32{x[31]}}, x};
    zx  = {32'd0, x};
    sy  = {{32{y[31]}}, y};
    zy  = {32'd0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (o)
      3'b000: begin p = sx * sy; return p[31:0];  end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * zy; return p[63:32]; end
      3'b011: begin p = zx * zy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(x) / $signed(y));
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (ovf) return 32'd0;
        return 32'($signed(x) % $signed(y));
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit ref_early(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[2]) return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    return (x == 0) || (y == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Cycle-level model: busy for a fixed number of edges after accept, then one done cycle.
  bit          m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = 32'd0, m_pend = 32'd0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (kill_md_i) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else m_left <= m_left - 1;
    end else if (valid_md_i && !kill_md_i) begin
      m_busy <= 1'b1;
      m_pend <= ref_res(op_md_i, opr_a_md_i, opr_b_md_i);
      m_left <= ref_early(op_md_i, opr_a_md_i, opr_b_md_i) ? 1 : 32;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'd0, ready_md_o}, {31'd0, !(m_busy || m_done)});
      chk("busy",  {31'd0, busy_md_o},  {31'd0, (m_busy || m_done)});
      chk("done",  {31'd0, done_md_o},  {31'd0, m_done});
      chk("res",   res_md_o, m_res);
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold, output logic [31:0] r, output int lat, output bit got);
    int start;
    @(negedge clk);
    valid_md_i = 1'b1; op_md_i = o; opr_a_md_i = x; opr_b_md_i = y;
    start = cyc;
    got = 1'b0; lat = 0; r = res_md_o;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1 && !hold) valid_md_i = 1'b0;
      if (done_md_o) begin
        got = 1'b1;
        lat = cyc - start;
        r   = res_md_o;
      end
    end
    valid_md_i = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    bit got;
    chk({name, "_model"}, ref_res(o, x, y), exp);
    do_op(o, x, y, 1'b0, r, lat, got);
    chk({name, "_res"}, r, exp);
    chk({name, "_lat"}, lat, ref_early(o, x, y) ? 32'd2 : 32'd33);
    $display("op %s a=%h b=%h res=%h lat=%0d", name, x, y, r, lat);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r, x, y, held;
    logic [2:0]  o;
    int lat, ndone;
    bit got;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_ready", {31'd0, ready_md_o}, 32'd1);
    chk("reset_res", res_md_o, 32'd0);
    reset_n = 1'b1;

    directed("MUL",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed("MULH",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    directed("MULHU",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("MULHSU", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed("DIV",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    directed("REM",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    directed("DIVU",   3'b101, 32'd100,        32'd7,         32'd14);
    directed("REMU",   3'b111, 32'd100,        32'd7,         32'd2);
    directed("DIVU0",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF);
    directed("REM0",   3'b110, 32'd5,          32'd0,         32'd5);
    directed("DIVOVF", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    directed("REMOVF", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    directed("MULZ",   3'b000, 32'd0,          32'd1234,      32'd0);

    // Kill ten cycles into a divide: no done, result held, then a fresh multiply.
    held = res_md_o;
    @(negedge clk);
    valid_md_i = 1'b1; op_md_i = 3'b100; opr_a_md_i = 32'd1000; opr_b_md_i = 32'd3;
    @(negedge clk);
    valid_md_i = 1'b0;
    repeat (9) @(negedge clk);
    kill_md_i = 1'b1;
    @(negedge clk);
    kill_md_i = 1'b0;
    chk("kill_ready", {31'd0, ready_md_o}, 32'd1);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_md_o) ndone++;
    end
    chk("kill_nodone", ndone, 32'd0);
    chk("kill_res", res_md_o, held);
    directed("MUL34", 3'b000, 32'd3, 32'd4, 32'd12);

    // Kill together with valid in IDLE: request must be dropped.
    @(negedge clk);
    valid_md_i = 1'b1; kill_md_i = 1'b1; op_md_i = 3'b000; opr_a_md_i = 32'd9; opr_b_md_i = 32'd9;
    @(negedge clk);
    valid_md_i = 1'b0; kill_md_i = 1'b0;
    chk("killvalid_ready", {31'd0, ready_md_o}, 32'd1);
    $display("op KILL+VALID in idle ready=%0b", ready_md_o);

    // Reset pulse mid-calculation.
    @(negedge clk);
    valid_md_i = 1'b1; op_md_i = 3'b101; opr_a_md_i = 32'd77; opr_b_md_i = 32'd5;
    @(negedge clk);
    valid_md_i = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_res", res_md_o, 32'd0);
    chk("midrst_ready", {31'd0, ready_md_o}, 32'd1);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_md_o) ndone++;
    end
    chk("midrst_nodone", ndone, 32'd0);
    $display("op RESET mid-calc res=%h", res_md_o);

    // Valid held through the whole operation yields a single done.
    do_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, r, lat, got);
    ndone = got ? 1 : 0;
    repeat (40) begin
      @(negedge clk);
      if (done_md_o) ndone++;
    end
    chk("hold_one_done", ndone, 32'd1);
    chk("hold_res", r, 32'h0B00_EA4E);
    $display("op MULHU held-valid res=%h dones=%0d", r, ndone);

    // Randomized ops, occasionally killed part-way.
    for (int t = 0; t < 48; t++) begin
      o = 3'($urandom_range(0, 7));
      x = rnd_opnd();
      y = rnd_opnd();
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        valid_md_i = 1'b1; op_md_i = o; opr_a_md_i = x; opr_b_md_i = y;
        @(negedge clk);
        valid_md_i = 1'b0;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        kill_md_i = 1'b1;
        @(negedge clk);
        kill_md_i = 1'b0;
        $display("op rnd%0d op=%0d a=%h b=%h killed", t, o, x, y);
      end else begin
        do_op(o, x, y, 1'($urandom_range(0, 1)), r, lat, got);
        chk("rnd_lat", lat, ref_early(o, x, y) ? 32'd2 : 32'd33);
        $display("op rnd%0d op=%0d a=%h b=%h res=%h lat=%0d", t, o, x, y, r, lat);
      end
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
